cache_line_mover: RTL and testbench
===================================

Name: cache_line_mover

Overview:
- Cache-side initiator for the CPU data-RAM port. Moves whole cache lines between the data cache and the synchronous, byte-enabled data RAM.
- Per request it optionally writes back a dirty victim line, then optionally refills a line. It streams words to and from the cache arrays.
- Sits between the data cache FSM and the RAM's A port. The RAM returns data one cycle after the address and uses a 4-bit write enable.

Parameters:
- LINE_WORDS, 8: words per line; power of two, 2..64.
- OFFSET_BITS, $clog2(LINE_WORDS)+2: byte-offset bits within a line; derived, never overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  cache requests a line transfer
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high
- req_wb  in  1  perform writeback of victim line
- req_wb_addr  in  32  victim byte address; low OFFSET_BITS ignored
- req_rf  in  1  perform refill
- req_rf_addr  in  32  refill byte address; bits [OFFSET_BITS-1:2] give the critical word
- wb_idx  out  $clog2(LINE_WORDS)  word index the cache must supply
- wb_word  in  32  victim word at wb_idx; combinational from the cache
- fill_valid  out  1  fill_word is valid for fill_idx this cycle
- fill_idx  out  $clog2(LINE_WORDS)  line word index of fill_word
- fill_word  out  32  pass-through of mem_dout
- done  out  1  one-cycle pulse when the transfer completes
- mem_addr  out  32  RAM byte address, registered
- mem_din  out  32  RAM write data, registered
- mem_we  out  4  RAM byte write enables, registered; only 4'h0 or 4'hF
- mem_dout  in  32  RAM read data, valid the cycle after its address

Behaviour:
- Reset, asynchronous, effective immediately, also mid-transfer:
  - state IDLE, counters 0, mem_we 0, mem_addr 0, mem_din 0.
  - fill_valid 0, done 0, req_ready 1.
  - The partial line is abandoned; the cache must reissue.
- States: IDLE, WB, RF_ISSUE, RF_DRAIN.
- IDLE, on accept (cycle 0):
  - Latch line bases: address with low OFFSET_BITS cleared.
  - req_wb=1 goes to WB; else req_rf=1 goes to RF_ISSUE.
  - Both 0: done pulses in cycle 1 and the state stays IDLE.
- WB, writeback:
  - cnt k runs 0..LINE_WORDS-1, one per cycle; wb_idx=k combinationally in cycle k+1.
  - Next cycle: mem_addr=wb_base+4k, mem_din=wb_word, mem_we=4'hF.
  - After the last index: go to RF_ISSUE if the latched req_rf is set; else done pulses together with the last mem_we cycle, then IDLE.
- RF_ISSUE, refill issue:
  - mem_we=0; one address per cycle, mem_addr=rf_base+4*idx(k).
  - Without the optional feature, idx(k)=k.
  - Exits to RF_DRAIN after the last issue.
- Read pipeline:
  - The address issued in cycle c produces fill_valid=1, fill_idx=idx(k), fill_word=mem_dout in cycle c+1.
  - A one-bit valid and an index delay register track this.
- RF_DRAIN: one cycle; the final fill_valid and done are asserted together, then IDLE.
- Latency, LINE_WORDS=8:
  - Refill only: addresses in cycles 1-8, fills in 2-9, done in 9.
  - Writeback only: writes driven in cycles 2-9, done in 9.
  - Both: writes in 2-9, refill addresses in 10-17, fills in 11-18, done in 18.
- Ordering: writeback always completes before the refill reads, so a same-line WB+RF returns the written-back data.
- req_valid is ignored outside IDLE; request inputs are sampled only at accept.
- Address arithmetic is 32-bit modulo; no range checking. The RAM returns 0 outside its window, and the mover forwards it unchanged.

Optional Feature:
- Macro: CACHE_MOVER_CRITICAL_WORD_FIRST_EN.
- Defined: refill order is idx(k)=(crit+k) mod LINE_WORDS, where crit=req_rf_addr[OFFSET_BITS-1:2]. The index wraps, and the first fill_valid carries the critical word.
- Undefined: idx(k)=k and crit is ignored.
- Latency is identical in both cases.

Decomposition:
- Package cache_mover_pkg holds:
  - the state enum (IDLE, WB, RF_ISSUE, RF_DRAIN)
  - the MEM_WE_FULL=4'hF and MEM_WE_NONE=4'h0 constants
  - the word-index width function
- One sub-module, mover_addr_gen: holds the counter, wrap/critical-word index and base+4*idx address, and is shared by WB and RF.

Test Plan:
- Refill only, rf_addr=0x0000_0040, RAM words 16..23 preloaded 0xA0..0xA7 -> fill_idx 0..7 in cycles 2..9 with fill_word 0xA0..0xA7; done in cycle 9; mem_we never nonzero.
- Writeback only, wb_addr=0x0000_0100, wb_word=0x1000+wb_idx -> mem_addr 0x100..0x11C with mem_din 0x1000..0x1007 and mem_we=F in cycles 2..9; done in cycle 9; RAM words 64..71 updated.
- WB+RF on the same line 0x80 -> refill returns the just-written values; done in cycle 18; req_ready=0 in cycles 1..18.
- With the macro, rf_addr=0x0000_005C (crit=7) -> fill_idx sequence 7,0,1,...,6; without it, 0..7.
- rst_n asserted in cycle 5 of a refill -> mem_we, fill_valid and done are 0 immediately and req_ready is 1; a new request completes normally.
- req_valid with req_wb=req_rf=0 -> done in cycle 1 with no RAM traffic; req_valid pulsed mid-transfer is ignored.

Source files
------------

// File: rtl/cache_mover_pkg.sv
// Shared types and constants for the cache line mover: FSM states,
// RAM write-enable encodings and the word-index width helper.
package cache_mover_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WB       = 2'd1,
        RF_ISSUE = 2'd2,
        RF_DRAIN = 2'd3
    } mover_state_e;

    localparam logic [3:0] MEM_WE_FULL = 4'hF;
    localparam logic [3:0] MEM_WE_NONE = 4'h0;

    // Width of a word index within a line; never narrower than one bit.
    function automatic int unsigned word_idx_w(input int unsigned line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/mover_addr_gen.sv
// Word counter plus (critical-word rotated) index and base+4*idx byte address,
// shared by the writeback and refill phases of the cache line mover.
module mover_addr_gen
    import cache_mover_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    localparam int IW = int'(word_idx_w(LINE_WORDS))
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          step,
    input  logic [31:0]   base,
    input  logic [IW-1:0] crit,
    output logic [IW-1:0] idx,
    output logic [31:0]   addr,
    output logic          last
);

    logic [IW-1:0] cnt_q;
    logic [IW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // LINE_WORDS is a power of two, so the IW-bit add wraps modulo the line.
    assign idx  = crit + cnt_q;
    assign addr = base + {{(30 - IW){1'b0}}, idx, 2'b00};
    assign last = (cnt_q == IW'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_line_mover.sv
// Moves cache lines between the data cache and the byte-enabled data RAM:
// optional victim writeback, then optional refill. Optional critical-word-first
// refill ordering is enabled by CACHE_MOVER_CRITICAL_WORD_FIRST_EN.
module cache_line_mover
    import cache_mover_pkg::*;
#(
    parameter int LINE_WORDS  = 8,
    parameter int OFFSET_BITS = $clog2(LINE_WORDS) + 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wb,
    input  logic [31:0]                   req_wb_addr,
    input  logic                          req_rf,
    input  logic [31:0]                   req_rf_addr,
    output logic [$clog2(LINE_WORDS)-1:0] wb_idx,
    input  logic [31:0]                   wb_word,
    output logic                          fill_valid,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic [31:0]                   fill_word,
    output logic                          done,
    output logic [31:0]                   mem_addr,
    output logic [31:0]                   mem_din,
    output logic [3:0]                    mem_we,
    input  logic [31:0]                   mem_dout
);

    localparam int IW = int'(word_idx_w(LINE_WORDS));
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

    mover_state_e  state_q, state_d;
    logic [31:0]   wb_base_q, wb_base_d;
    logic [31:0]   rf_base_q, rf_base_d;
    logic [IW-1:0] crit_q, crit_d;
    logic          rf_pend_q, rf_pend_d;
    logic          issued_all_q, issued_all_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_din_q, mem_din_d;
    logic [3:0]    mem_we_q, mem_we_d;
    logic          bus_rd_q, bus_rd_d;
    logic [IW-1:0] bus_idx_q, bus_idx_d;
    logic          fill_valid_q;
    logic [IW-1:0] fill_idx_q;
    logic          done_q, done_d;

    logic          accept;
    logic [IW-1:0] req_crit;
    logic          gen_clr, gen_step, gen_last;
    logic [31:0]   gen_base, gen_addr;
    logic [IW-1:0] gen_crit, gen_idx;

    assign accept = req_valid && (state_q == IDLE);

`ifdef CACHE_MOVER_CRITICAL_WORD_FIRST_EN
    assign req_crit = req_rf_addr[OFFSET_BITS-1:2];
`else
    assign req_crit = '0;
`endif

    mover_addr_gen #(.LINE_WORDS(LINE_WORDS)) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (gen_clr),
        .step  (gen_step),
        .base  (gen_base),
        .crit  (gen_crit),
        .idx   (gen_idx),
        .addr  (gen_addr),
        .last  (gen_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wb_base_q    <= '0;
            rf_base_q    <= '0;
            crit_q       <= '0;
            rf_pend_q    <= 1'b0;
            issued_all_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= MEM_WE_NONE;
            bus_rd_q     <= 1'b0;
            bus_idx_q    <= '0;
            fill_valid_q <= 1'b0;
            fill_idx_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wb_base_q    <= wb_base_d;
            rf_base_q    <= rf_base_d;
            crit_q       <= crit_d;
            rf_pend_q    <= rf_pend_d;
            issued_all_q <= issued_all_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
            bus_rd_q     <= bus_rd_d;
            bus_idx_q    <= bus_idx_d;
            fill_valid_q <= bus_rd_q;
            fill_idx_q   <= bus_idx_q;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_wb) begin
                        state_d = WB;
                    end else if (req_rf) begin
                        state_d = RF_ISSUE;
                    end
                end
            end
            WB: begin
                if (gen_last) begin
                    state_d = rf_pend_q ? RF_ISSUE : IDLE;
                end
            end
            RF_ISSUE: begin
                if (issued_all_q) begin
                    state_d = RF_DRAIN;
                end
            end
            RF_DRAIN: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // mem_addr is registered, so each state computes the address the RAM sees
    // next cycle; a refill-only request issues its first read straight from IDLE.
    always_comb begin
        wb_base_d    = wb_base_q;
        rf_base_d    = rf_base_q;
        crit_d       = crit_q;
        rf_pend_d    = rf_pend_q;
        issued_all_d = issued_all_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_d     = MEM_WE_NONE;
        bus_rd_d     = 1'b0;
        bus_idx_d    = bus_idx_q;
        done_d       = 1'b0;
        gen_clr      = 1'b0;
        gen_step     = 1'b0;
        gen_base     = rf_base_q;
        gen_crit     = crit_q;
        case (state_q)
            IDLE: begin
                gen_base = req_rf_addr & LINE_MASK;
                gen_crit = req_crit;
                gen_clr  = 1'b1;
                if (accept) begin
                    wb_base_d    = req_wb_addr & LINE_MASK;
                    rf_base_d    = req_rf_addr & LINE_MASK;
                    crit_d       = req_crit;
                    rf_pend_d    = req_rf;
                    issued_all_d = 1'b0;
                    if (!req_wb && req_rf) begin
                        mem_addr_d = gen_addr;
                        bus_rd_d   = 1'b1;
                        bus_idx_d  = gen_idx;
                        gen_clr    = 1'b0;
                        gen_step   = 1'b1;
                    end
                    if (!req_wb && !req_rf) begin
                        done_d = 1'b1;
                    end
                end
            end
            WB: begin
                gen_base   = wb_base_q;
                gen_crit   = '0;
                mem_addr_d = gen_addr;
                mem_din_d  = wb_word;
                mem_we_d   = MEM_WE_FULL;
                gen_step   = 1'b1;
                if (gen_last) begin
                    gen_clr = 1'b1;
                    done_d  = !rf_pend_q;
                end
            end
            RF_ISSUE: begin
                if (!issued_all_q) begin
                    mem_addr_d = gen_addr;
                    bus_rd_d   = 1'b1;
                    bus_idx_d  = gen_idx;
                    gen_step   = 1'b1;
                    if (gen_last) begin
                        issued_all_d = 1'b1;
                        gen_clr      = 1'b1;
                    end
                end
            end
            RF_DRAIN: begin
                issued_all_d = 1'b0;
            end
            default: begin
                gen_clr = 1'b1;
            end
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign wb_idx     = gen_idx;
    assign fill_valid = fill_valid_q;
    assign fill_idx   = fill_idx_q;
    assign fill_word  = mem_dout;
    assign done       = done_q || (state_q == RF_DRAIN);
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_cache_line_mover.sv
// Self-checking bench for cache_line_mover: a behavioural RAM, a line-level
// reference model of memory contents and transfer timing, directed and random requests.
module tb_cache_line_mover;

    localparam int N   = 8;
    localparam int IW  = $clog2(N);
    localparam int OFF = $clog2(N) + 2;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF) - 32'd1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wb = 1'b0;
    logic [31:0]   req_wb_addr = '0;
    logic          req_rf = 1'b0;
    logic [31:0]   req_rf_addr = '0;
    logic [IW-1:0] wb_idx;
    logic [31:0]   wb_word;
    logic          fill_valid;
    logic [IW-1:0] fill_idx;
    logic [31:0]   fill_word;
    logic          done;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_din;
    logic [3:0]    mem_we;
    logic [31:0]   mem_dout = '0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]   victim [N];
    logic [31:0]   ram [256];
    logic [31:0]   ref_mem [256];
    logic          pre_en = 1'b0;
    logic [7:0]    pre_addr = '0;
    logic [31:0]   pre_data = '0;
    logic [31:0]   exp_q[$];
    logic [IW-1:0] exp_idx_q[$];

    always #5 clk = ~clk;

    cache_line_mover #(.LINE_WORDS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wb      (req_wb),
        .req_wb_addr (req_wb_addr),
        .req_rf      (req_rf),
        .req_rf_addr (req_rf_addr),
        .wb_idx      (wb_idx),
        .wb_word     (wb_word),
        .fill_valid  (fill_valid),
        .fill_idx    (fill_idx),
        .fill_word   (fill_word),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_dout    (mem_dout)
    );

    assign wb_word = victim[wb_idx];

    // Synchronous byte-enabled RAM with a 1 KiB window; reads outside return 0.
    always @(posedge clk) begin
        logic [31:0] m;
        m = {{8{mem_we[3]}}, {8{mem_we[2]}}, {8{mem_we[1]}}, {8{mem_we[0]}}};
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_addr < 32'h400) begin
            ram[mem_addr[9:2]] <= (ram[mem_addr[9:2]] & ~m) | (mem_din & m);
        end
        mem_dout <= (mem_addr < 32'h400) ? ram[mem_addr[9:2]] : 32'h0;
    end

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return (a < 32'h400) ? ref_mem[a[9:2]] : 32'h0;
    endfunction

    task automatic preload_all();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pre_en   = 1'b1;
            pre_addr = 8'(i);
            pre_data = (i >= 16 && i < 24) ? 32'hA0 + 32'(i - 16) : $urandom;
            ref_mem[i] = pre_data;
        end
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // One complete request, every cycle checked against the line-level model.
    task automatic run_xfer(input bit wb, input logic [31:0] wa, input bit rf,
                            input logic [31:0] ra, input bit pulse_mid);
        logic [31:0] wbase, rbase, e_addr;
        int          crit, done_c, rd_start, idx;
        bit          exp_we, exp_fv;
        logic [IW-1:0] e_idx;
        wbase = wa & LINE_MASK;
        rbase = ra & LINE_MASK;
`ifdef CACHE_MOVER_CRITICAL_WORD_FIRST_EN
        crit = int'(ra[OFF-1:2]);
`else
        crit = 0;
`endif
        // writeback lands before any refill read, so reads see the victim data
        if (wb) begin
            for (int k = 0; k < N; k++) begin
                e_addr = wbase + 32'(4 * k);
                if (e_addr < 32'h400) ref_mem[e_addr[9:2]] = victim[k];
            end
        end
        exp_q.delete();
        exp_idx_q.delete();
        if (rf) begin
            for (int k = 0; k < N; k++) begin
                idx = (crit + k) % N;
                exp_idx_q.push_back(IW'(idx));
                exp_q.push_back(ref_read(rbase + 32'(4 * idx)));
            end
        end
        done_c   = (!wb && !rf) ? 1 : ((wb && rf) ? 2 * N + 2 : N + 1);
        rd_start = wb ? N + 3 : 2;

        @(negedge clk);
        req_valid = 1'b1; req_wb = wb; req_wb_addr = wa; req_rf = rf; req_rf_addr = ra;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL accept_ready: got %b want 1", req_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_wb = $urandom_range(0, 1); req_rf = $urandom_range(0, 1);
        req_wb_addr = $urandom; req_rf_addr = $urandom;

        for (int n = 1; n <= done_c + 1; n++) begin
            @(negedge clk);
            exp_we = wb && n >= 2 && n <= N + 1;
            n_checks++;
            if (mem_we !== (exp_we ? 4'hF : 4'h0))
                $display("FAIL mem_we c%0d: got %h want %h", n, mem_we, exp_we ? 4'hF : 4'h0);
            else n_pass++;
            if (exp_we) begin
                e_addr = wbase + 32'(4 * (n - 2));
                n_checks++;
                if (mem_addr !== e_addr) $display("FAIL wb_addr c%0d: got %h want %h", n, mem_addr, e_addr);
                else n_pass++;
                n_checks++;
                if (mem_din !== victim[n - 2]) $display("FAIL wb_din c%0d: got %h want %h", n, mem_din, victim[n - 2]);
                else n_pass++;
            end
            if (rf && n >= rd_start - 1 && n < rd_start - 1 + N) begin
                e_addr = rbase + 32'(4 * ((crit + n - rd_start + 1) % N));
                n_checks++;
                if (mem_addr !== e_addr) $display("FAIL rd_addr c%0d: got %h want %h", n, mem_addr, e_addr);
                else n_pass++;
            end
            exp_fv = rf && n >= rd_start && n < rd_start + N;
            n_checks++;
            if (fill_valid !== exp_fv) $display("FAIL fill_valid c%0d: got %b want %b", n, fill_valid, exp_fv);
            else n_pass++;
            if (exp_fv) begin
                e_idx  = exp_idx_q.pop_front();
                e_addr = exp_q.pop_front();
                n_checks++;
                if (fill_idx !== e_idx) $display("FAIL fill_idx c%0d: got %0d want %0d", n, fill_idx, e_idx);
                else n_pass++;
                n_checks++;
                if (fill_word !== e_addr) $display("FAIL fill_word c%0d: got %h want %h", n, fill_word, e_addr);
                else n_pass++;
            end
            n_checks++;
            if (done !== (n == done_c)) $display("FAIL done c%0d: got %b want %b", n, done, n == done_c);
            else n_pass++;
            if (n != done_c) begin
                n_checks++;
                if (req_ready !== (n > done_c)) $display("FAIL req_ready c%0d: got %b want %b", n, req_ready, n > done_c);
                else n_pass++;
            end
            if (pulse_mid && n == 3) begin
                req_valid = 1'b1; req_wb = 1'b1; req_rf = 1'b1;
                req_wb_addr = $urandom_range(0, 32'h3FF); req_rf_addr = $urandom_range(0, 32'h3FF);
            end
            if (n == 4) req_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_we !== 4'h0 || mem_addr !== 32'h0 || mem_din !== 32'h0)
            $display("FAIL reset_mem: got we=%h addr=%h din=%h want 0 0 0", mem_we, mem_addr, mem_din);
        else n_pass++;
        n_checks++;
        if (fill_valid !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL reset_ctl: got fv=%b done=%b rdy=%b want 0 0 1", fill_valid, done, req_ready);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_refill_only();
        run_xfer(1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b0);
    endtask

    task automatic test_critical_word();
        run_xfer(1'b0, 32'h0, 1'b1, 32'h0000_005C, 1'b0);
    endtask

    task automatic test_writeback_only();
        for (int i = 0; i < N; i++) victim[i] = 32'h1000 + 32'(i);
        run_xfer(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (ram[64 + i] !== 32'h1000 + 32'(i))
                $display("FAIL ram_word %0d: got %h want %h", 64 + i, ram[64 + i], 32'h1000 + 32'(i));
            else n_pass++;
        end
    endtask

    task automatic test_wb_rf_same_line();
        for (int i = 0; i < N; i++) victim[i] = 32'h5A00 + 32'(i);
        run_xfer(1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080, 1'b0);
    endtask

    task automatic test_noop_and_mid_valid();
        run_xfer(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        run_xfer(1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b1);
        for (int i = 0; i < N; i++) victim[i] = $urandom;
        run_xfer(1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid_transfer();
        @(negedge clk);
        req_valid = 1'b1; req_wb = 1'b0; req_rf = 1'b1; req_rf_addr = 32'h0000_0040;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (fill_valid !== 1'b1) $display("FAIL pre_reset_fill: got %b want 1", fill_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_we !== 4'h0 || fill_valid !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'h0)
            $display("FAIL mid_reset: got we=%h fv=%b done=%b rdy=%b addr=%h want 0 0 0 1 0",
                     mem_we, fill_valid, done, req_ready, mem_addr);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer(1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b0);
    endtask

    task automatic test_random();
        bit          wb, rf, pulse;
        logic [31:0] wa, ra;
        for (int t = 0; t < 24; t++) begin
            wb    = $urandom_range(0, 1);
            rf    = $urandom_range(0, 1);
            pulse = $urandom_range(0, 1) && (wb || rf);
            wa    = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FF));
            ra    = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FF));
            for (int i = 0; i < N; i++) victim[i] = $urandom;
            run_xfer(wb, wa, rf, ra, pulse);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) victim[i] = '0;
        test_reset();
        preload_all();
        test_refill_only();
        test_critical_word();
        test_writeback_only();
        test_wb_rf_same_line();
        test_noop_and_mid_valid();
        test_reset_mid_transfer();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
